// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared types and WM8731 register words for the codec configuration sequencer.
// Build option CODEC_CFG_RESET_EN adds a codec reset write ahead of the table.
package codec_cfg_sequencer_pkg;

    localparam logic [7:0] CODEC_ADDR_W    = 8'h34;
    localparam int         CFG_TABLE_DEPTH = 10;

`ifdef CODEC_CFG_RESET_EN
    localparam int RESET_ENTRIES = 1;
`else
    localparam int RESET_ENTRIES = 0;
`endif

    // Register words are {reg[6:0], data[8:0]} as the WM8731 expects them on the wire
    localparam logic [15:0] REG_RESET     = 16'h1E00;
    localparam logic [15:0] REG_LLINE_IN  = 16'h0017;
    localparam logic [15:0] REG_RLINE_IN  = 16'h0217;
    localparam logic [15:0] REG_LHP_OUT   = 16'h047F;
    localparam logic [15:0] REG_RHP_OUT   = 16'h067F;
    localparam logic [15:0] REG_AN_PATH   = 16'h0812;
    localparam logic [15:0] REG_DIG_PATH  = 16'h0A06;
    localparam logic [15:0] REG_PWR_DOWN  = 16'h0C00;
    localparam logic [15:0] REG_DIG_IFACE = 16'h0E01;
    localparam logic [15:0] REG_SRATE     = 16'h1002;
    localparam logic [15:0] REG_ACTIVE    = 16'h1201;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_XFER,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    function automatic logic [23:0] cfg_frame(input logic [7:0] addr, input logic [15:0] word);
        return {addr, word};
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Handshake between the configuration sequencer and the 3-byte I2C write serializer.
interface codec_cfg_sequencer_if;
    logic [23:0] i2c_data;
    logic        start;
    logic        tr_end;
    logic        ack;

    modport master (output i2c_data, output start, input tr_end, input ack);
    modport slave  (input i2c_data, input start, output tr_end, output ack);
endinterface

// File: rtl/codec_cfg_rom.sv
// Index -> register word lookup for the power-up sequence.
// With CODEC_CFG_RESET_EN the reset write sits at index 0 and the table follows it.
module codec_cfg_rom
    import codec_cfg_sequencer_pkg::*;
(
    input  logic [4:0]  index,
    output logic [15:0] word
);
    logic [4:0] tidx;

    always_comb begin
        tidx = index - 5'(RESET_ENTRIES);
        word = '0;
        case (tidx)
            5'd0:    word = REG_LLINE_IN;
            5'd1:    word = REG_RLINE_IN;
            5'd2:    word = REG_LHP_OUT;
            5'd3:    word = REG_RHP_OUT;
            5'd4:    word = REG_AN_PATH;
            5'd5:    word = REG_DIG_PATH;
            5'd6:    word = REG_PWR_DOWN;
            5'd7:    word = REG_DIG_IFACE;
            5'd8:    word = REG_SRATE;
            5'd9:    word = REG_ACTIVE;
            default: word = '0;
        endcase
`ifdef CODEC_CFG_RESET_EN
        if (index == 5'd0) word = REG_RESET;
`endif
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// WM8731 power-up sequencer: one {DEV_ADDR, word} write per table entry, with retry on NACK/timeout.
// Build option CODEC_CFG_RESET_EN prepends a codec reset write (one extra entry).
module codec_cfg_sequencer
    import codec_cfg_sequencer_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR   = CODEC_ADDR_W,
    parameter int         NUM_REGS   = CFG_TABLE_DEPTH,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 64,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic                          clock_i2c,
    input  logic                          reset_n,
    input  logic                          go,
    codec_cfg_sequencer_if.master         ser,
    output logic                          busy,
    output logic                          cfg_done,
    output logic                          cfg_err,
    output logic [4:0]                    cur_index,
    output logic [1:0]                    retry_cnt
);
    localparam int               NUM_WRITES = NUM_REGS + RESET_ENTRIES;
    localparam logic [4:0]       LAST_IDX   = 5'(NUM_WRITES - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);
    localparam int               CNT_W      = $clog2(TIMEOUT + GAP_CYCLES + 2) + 1;
    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    cfg_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timed_out, tmo_nxt;
    logic             xfer_fail, restart;
    logic [15:0]      rom_word;
    logic [23:0]      data_nxt;
    logic             start_nxt, busy_nxt, done_nxt, err_nxt;
    logic [4:0]       idx_nxt;
    logic [1:0]       rc_nxt;

    codec_cfg_rom u_rom (
        .index (cur_index),
        .word  (rom_word)
    );

    // A watchdog expiry counts as a failed attempt exactly like a NACK
    assign xfer_fail = timed_out || ser.ack;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (AUTO_START || go) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ARM;
            ST_ARM:   if (cnt == ARM_LAST) state_nxt = ST_XFER;
            ST_XFER:  if (ser.tr_end || cnt == XFER_LAST) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!xfer_fail)
                    state_nxt = (cur_index == LAST_IDX) ? ST_DONE : ST_GAP;
                else
                    state_nxt = (retry_cnt < RETRY_MAX) ? ST_GAP : ST_ERROR;
            end
            ST_GAP:   if (cnt == GAP_LAST) state_nxt = ST_LOAD;
            ST_DONE,
            ST_ERROR: if (go) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase

        restart = (state_nxt == ST_LOAD) &&
                  (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

        // One counter serves ARM, XFER watchdog and GAP; it restarts on every state change
        cnt_nxt = (state_nxt == state) ? cnt + 1'b1 : '0;
        tmo_nxt = (state == ST_XFER) && !ser.tr_end;

        idx_nxt = cur_index;
        rc_nxt  = retry_cnt;
        if (restart) begin
            idx_nxt = '0;
            rc_nxt  = '0;
        end else if (state == ST_CHECK) begin
            if (!xfer_fail) begin
                rc_nxt = '0;
                if (state_nxt == ST_GAP) idx_nxt = cur_index + 5'd1;
            end else if (state_nxt == ST_GAP) begin
                rc_nxt = retry_cnt + 2'd1;
            end
        end

        data_nxt  = (state == ST_LOAD) ? cfg_frame(DEV_ADDR, rom_word) : ser.i2c_data;
        start_nxt = (state_nxt == ST_XFER) || (state_nxt == ST_CHECK);
        busy_nxt  = !(state_nxt == ST_IDLE || state_nxt == ST_DONE || state_nxt == ST_ERROR);
        done_nxt  = (state_nxt == ST_DONE);
        err_nxt   = (state_nxt == ST_ERROR);
    end

    // Outputs are registered from next-state values so they line up with the state they belong to
    always_ff @(posedge clock_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            timed_out    <= 1'b0;
            ser.i2c_data <= '0;
            ser.start    <= 1'b0;
            busy         <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            cur_index    <= '0;
            retry_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            timed_out    <= tmo_nxt;
            ser.i2c_data <= data_nxt;
            ser.start    <= start_nxt;
            busy         <= busy_nxt;
            cfg_done     <= done_nxt;
            cfg_err      <= err_nxt;
            cur_index    <= idx_nxt;
            retry_cnt    <= rc_nxt;
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: serializer model, attempt log and transaction-level reference.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;
    localparam int NUM_REGS   = 10;
    localparam int MAX_RETRY  = 3;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 64;
    localparam int LAT        = 3;
    localparam int BOUND      = 6000;
`ifdef CODEC_CFG_RESET_EN
    localparam int RST = 1;
`else
    localparam int RST = 0;
`endif
    localparam int NW = NUM_REGS + RST;

    logic       clock_i2c = 1'b0;
    logic       reset_n   = 1'b0;
    logic       go        = 1'b0;
    logic       busy, cfg_done, cfg_err;
    logic [4:0] cur_index;
    logic [1:0] retry_cnt;

    codec_cfg_sequencer_if bus ();

    codec_cfg_sequencer #(
        .NUM_REGS   (NUM_REGS),
        .MAX_RETRY  (MAX_RETRY),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .AUTO_START (1'b1)
    ) dut (
        .clock_i2c (clock_i2c),
        .reset_n   (reset_n),
        .go        (go),
        .ser       (bus),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cur_index (cur_index),
        .retry_cnt (retry_cnt)
    );

    always #5 clock_i2c = ~clock_i2c;

    logic [15:0] tbl [10] = '{16'h0017, 16'h0217, 16'h047F, 16'h067F, 16'h0812,
                              16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

    function automatic logic [23:0] word_of(input int i);
        if (RST == 1 && i == 0) return 24'h341E00;
        return {8'h34, tbl[i - RST]};
    endfunction

    function automatic int entry_of(input logic [23:0] w);
        for (int i = 0; i < NW; i++) if (word_of(i) == w) return i;
        return 15;
    endfunction

    typedef struct { logic [23:0] word; int retry; int low_run; } att_t;
    typedef struct { logic [23:0] word; int retry; bit hang; } exp_t;
    typedef struct { int fent; int fcnt; bit hng; int xw; bit xd; bit xe; int xi; int xr; } vec_t;

    att_t log_q[$];
    int   high_q[$];
    exp_t exp_q[$];
    int   fail_n[16];
    int   att_n[16];
    bit   hang;
    int   checks = 0, errors = 0;
    bit   m_done, m_err;
    int   m_idx, m_rc;

    // Serializer stand-in and attempt logger, both on the falling edge
    int   sc = 0, low_run = 0, high_run = 0, m_e;
    bit   cur_hang = 1'b0, m_fail;
    logic prev_start = 1'b0;
    att_t a;
    always @(negedge clock_i2c) begin
        if (bus.start !== 1'b1) begin
            if (prev_start === 1'b1) high_q.push_back(high_run);
            sc = 0;
            bus.tr_end = 1'b0;
            low_run++;
        end else begin
            if (prev_start !== 1'b1) begin
                m_e    = entry_of(bus.i2c_data);
                m_fail = att_n[m_e] < fail_n[m_e];
                att_n[m_e]++;
                cur_hang  = hang && m_fail;
                bus.ack   = m_fail;
                a.word    = bus.i2c_data;
                a.retry   = int'(retry_cnt);
                a.low_run = low_run;
                log_q.push_back(a);
                low_run  = 0;
                high_run = 0;
            end
            sc++;
            high_run++;
            if (sc == LAT && !cur_hang) bus.tr_end = 1'b1;
        end
        prev_start = bus.start;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each entry gets up to 1+MAX_RETRY attempts; the first non-failing one advances
    function automatic void model();
        exp_t x;
        bit   f;
        exp_q.delete();
        m_done = 1'b0; m_err = 1'b0; m_idx = 0; m_rc = 0;
        for (int e = 0; e < NW; e++) begin
            m_idx = e;
            for (int r = 0; r <= MAX_RETRY; r++) begin
                f      = r < fail_n[e];
                x.word = word_of(e); x.retry = r; x.hang = f && hang;
                exp_q.push_back(x);
                if (!f) break;
                if (r == MAX_RETRY) begin
                    m_err = 1'b1; m_rc = r;
                    return;
                end
            end
        end
        m_done = 1'b1; m_idx = NW - 1; m_rc = 0;
    endfunction

    task automatic clear_log();
        log_q.delete();
        high_q.delete();
        low_run = 0;
        foreach (att_n[k]) att_n[k] = 0;
    endtask

    task automatic restart_by_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock_i2c);
        clear_log();
        reset_n = 1'b1;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        @(negedge clock_i2c);
        while (!(cfg_done || cfg_err) && n < BOUND) begin
            @(negedge clock_i2c);
            n++;
        end
        chk({name, " finished"}, 32'(cfg_done | cfg_err), 32'd1);
        repeat (30) @(negedge clock_i2c);
    endtask

    task automatic compare(input string name);
        chk({name, " writes"}, log_q.size(), exp_q.size());
        chk({name, " done"}, 32'(cfg_done), 32'(m_done));
        chk({name, " err"}, 32'(cfg_err), 32'(m_err));
        chk({name, " index"}, 32'(cur_index), m_idx);
        chk({name, " retry"}, 32'(retry_cnt), m_rc);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " start"}, 32'(bus.start), 32'd0);
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s att%0d word", name, i), 32'(log_q[i].word), 32'(exp_q[i].word));
            chk($sformatf("%s att%0d retry", name, i), log_q[i].retry, exp_q[i].retry);
            if (i > 0)
                chk($sformatf("%s att%0d low", name, i), log_q[i].low_run, GAP_CYCLES + 3);
            if (i < high_q.size())
                chk($sformatf("%s att%0d high", name, i), high_q[i],
                    exp_q[i].hang ? TIMEOUT + 1 : LAT + 1);
        end
    endtask

    task automatic wait_log(input string name, input int n);
        int c = 0;
        while (log_q.size() < n && c < BOUND) begin
            @(negedge clock_i2c);
            c++;
        end
        chk({name, " reached"}, 32'(log_q.size() >= n), 32'd1);
    endtask

    vec_t vt[4];
    string nm;

    initial begin
        vt[0] = '{fent: 0, fcnt: 0, hng: 1'b0, xw: NW,     xd: 1'b1, xe: 1'b0, xi: NW - 1, xr: 0};
        vt[1] = '{fent: 3, fcnt: 1, hng: 1'b0, xw: NW + 1, xd: 1'b1, xe: 1'b0, xi: NW - 1, xr: 0};
        vt[2] = '{fent: 5, fcnt: 9, hng: 1'b0, xw: 9,      xd: 1'b0, xe: 1'b1, xi: 5,      xr: 3};
        vt[3] = '{fent: 0, fcnt: 9, hng: 1'b1, xw: 4,      xd: 1'b0, xe: 1'b1, xi: 0,      xr: 3};

        repeat (2) @(negedge clock_i2c);
        chk("reset i2c_data", 32'(bus.i2c_data), 32'd0);
        chk("reset start", 32'(bus.start), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(cfg_done), 32'd0);
        chk("reset err", 32'(cfg_err), 32'd0);
        chk("reset index", 32'(cur_index), 32'd0);
        chk("reset retry", 32'(retry_cnt), 32'd0);

        for (int i = 0; i < 4; i++) begin
            nm = $sformatf("vec%0d", i);
            foreach (fail_n[k]) fail_n[k] = 0;
            fail_n[vt[i].fent] = vt[i].fcnt;
            hang = vt[i].hng;
            model();
            restart_by_reset();
            wait_end(nm);
            compare(nm);
            chk({nm, " tbl writes"}, log_q.size(), vt[i].xw);
            chk({nm, " tbl done"}, 32'(cfg_done), 32'(vt[i].xd));
            chk({nm, " tbl err"}, 32'(cfg_err), 32'(vt[i].xe));
            chk({nm, " tbl index"}, 32'(cur_index), vt[i].xi);
            chk({nm, " tbl retry"}, 32'(retry_cnt), vt[i].xr);
        end

        for (int s = 0; s < 6; s++) begin
            nm = $sformatf("rand%0d", s);
            foreach (fail_n[k])
                fail_n[k] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
            hang = ($urandom_range(0, 3) == 0);
            model();
            restart_by_reset();
            wait_end(nm);
            compare(nm);
        end

        // Reset while entry 4 is on the wire
        foreach (fail_n[k]) fail_n[k] = 0;
        hang = 1'b0;
        model();
        restart_by_reset();
        wait_log("midreset", 5);
        @(negedge clock_i2c);
        chk("midreset start before", 32'(bus.start), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset i2c_data", 32'(bus.i2c_data), 32'd0);
        chk("midreset start", 32'(bus.start), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(cfg_done), 32'd0);
        chk("midreset err", 32'(cfg_err), 32'd0);
        chk("midreset index", 32'(cur_index), 32'd0);
        chk("midreset retry", 32'(retry_cnt), 32'd0);
        repeat (2) @(negedge clock_i2c);
        clear_log();
        reset_n = 1'b1;
        wait_end("after reset");
        compare("after reset");
        if (log_q.size() > 0) chk("after reset first word", 32'(log_q[0].word), 32'(word_of(0)));

        // go in DONE reruns; go while busy is ignored
        clear_log();
        go = 1'b1;
        @(negedge clock_i2c);
        go = 1'b0;
        wait_log("rerun", 3);
        @(negedge clock_i2c);
        go = 1'b1;
        @(negedge clock_i2c);
        go = 1'b0;
        chk("go busy index", 32'(cur_index), 32'd2);
        wait_end("rerun");
        compare("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
